adc_capture_writer: RTL and testbench

Producer side of the audio sample buffer. Periodically triggers the 8-bit parallel ADC, waits for its end-of-conversion strobe, and writes each sample into alternating halves of the ping-pong buffer. When a half is full it hands it to the pitch-analysis reader through a ready/ack handshake. It drives the buffer's write port and reports overruns and ADC timeouts.

---
 rtl/adc_capture_writer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_adc_capture_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_writer.sv
// adc_capture_writer
//
// Producer side of the ping-pong audio sample buffer. A free-running tick
// paces conversions on an 8-bit parallel ADC. Each sample is latched on the
// synchronised rising edge of EOC and written into the buffer at the current
// write pointer. Each time a half of the buffer fills, the half is handed to
// the reader through a half_ready/half_ack handshake.
//
// Ports:
//   clk         system clock, the only clock in this block
//   reset       asynchronous active-high reset, clears all state
//   enable      run request; the tick counter advances only while high
//   din         ADC parallel data, asynchronous, stable while eoc is high
//   eoc         ADC end of conversion, asynchronous, rising edge = data valid
//   conv_start  ADC conversion-start pulse, CONV_PULSE_CLKS cycles wide
//   address     buffer write address (current write pointer)
//   data_in     buffer write data (last captured sample)
//   write       one-cycle buffer write strobe
//   half_ready  one-cycle pulse, cycle after the last word of a half is written
//   ready_half  which half is full (0 = lower, 1 = upper), held between pulses
//   half_ack    reader has taken the pending half
//   overrun     sticky: a half completed while the previous one was unacked
//   timeout     sticky: EOC did not arrive within EOC_TIMEOUT_CLKS at least once

module adc_capture_writer #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned DEPTH            = 512,
    parameter int unsigned ADDRESS_WIDTH    = $clog2(DEPTH),
    parameter int unsigned CLKS_PER_SAMPLE  = 6000,
    parameter int unsigned CONV_PULSE_CLKS  = 4,
    parameter int unsigned EOC_TIMEOUT_CLKS = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     eoc,
    output logic                     conv_start,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    data_in,
    output logic                     write,
    output logic                     half_ready,
    output logic                     ready_half,
    input  logic                     half_ack,
    output logic                     overrun,
    output logic                     timeout
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int unsigned TickW    = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int unsigned PhaseMax = (CONV_PULSE_CLKS > EOC_TIMEOUT_CLKS) ?
                                       CONV_PULSE_CLKS : EOC_TIMEOUT_CLKS;
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);

    localparam logic [TickW-1:0]  TickLast    = TickW'(CLKS_PER_SAMPLE - 1);
    localparam logic [PhaseW-1:0] PulseLast   = PhaseW'(CONV_PULSE_CLKS - 1);
    localparam logic [PhaseW-1:0] TimeoutLast = PhaseW'(EOC_TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitEoc,
        StWrite,
        StWaitTick
    } state_e;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [PhaseW-1:0]   phase_cnt_q, phase_cnt_d;
    logic [TickW-1:0]    tick_cnt_q;
    logic                tick;

    logic                eoc_meta_q, eoc_sync_q, eoc_prev_q, eoc_rise_q;

    logic [ADDRESS_WIDTH-1:0] ptr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     half_ready_q, ready_half_q;
    logic                     pending_q, overrun_q, timeout_q;

    logic                capture;
    logic                timeout_set;
    logic                writing;
    logic                half_done;

    // ------------------------------------------------------------------
    // Sample-period tick: counts only while enabled, fires on the wrap cycle
    // ------------------------------------------------------------------
    assign tick = enable && (tick_cnt_q == TickLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (enable) begin
            if (tick_cnt_q == TickLast) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // EOC synchroniser and registered rising-edge detect. The edge flag is
    // registered so the FSM sees a clean single-cycle pulse; din is sampled
    // unsynchronised while that pulse is high, which is safe because the
    // ADC holds din stable for as long as eoc is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eoc_meta_q <= 1'b0;
            eoc_sync_q <= 1'b0;
            eoc_prev_q <= 1'b0;
            eoc_rise_q <= 1'b0;
        end else begin
            eoc_meta_q <= eoc;
            eoc_sync_q <= eoc_meta_q;
            eoc_prev_q <= eoc_sync_q;
            eoc_rise_q <= eoc_sync_q & ~eoc_prev_q;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        capture     = 1'b0;
        timeout_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d     = StStart;
                    phase_cnt_d = '0;
                end
            end

            StStart: begin
                if (phase_cnt_q == PulseLast) begin
                    state_d     = StWaitEoc;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q + PhaseW'(1);
                end
            end

            StWaitEoc: begin
                // An edge in the final counted cycle still wins over timeout.
                if (eoc_rise_q) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end else if (phase_cnt_q == TimeoutLast) begin
                    timeout_set = 1'b1;
                    state_d     = StWaitTick;
                end else begin
                    phase_cnt_d = phase_cnt_q + PhaseW'(1);
                end
            end

            StWrite: begin
                // A sample already in flight always completes; enable only
                // decides whether another one is scheduled.
                state_d = enable ? StWaitTick : StIdle;
            end

            StWaitTick: begin
                // With enable low the tick counter is frozen, so park in
                // IDLE rather than wait for a tick that cannot arrive.
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    state_d     = StStart;
                    phase_cnt_d = '0;
                end
            end

            default: begin
                state_d     = StIdle;
                phase_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write pointer, sample register and half completion
    // ------------------------------------------------------------------
    assign writing = (state_q == StWrite);

    // Last word of either half: all address bits below the half-select bit set.
    assign half_done = &ptr_q[ADDRESS_WIDTH-2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (capture) begin
            data_q <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            half_ready_q <= 1'b0;
            ready_half_q <= 1'b0;
        end else begin
            half_ready_q <= 1'b0;
            if (writing) begin
                // DEPTH is a power of two, so the natural wrap is modulo DEPTH.
                ptr_q <= ptr_q + ADDRESS_WIDTH'(1);
                if (half_done) begin
                    half_ready_q <= 1'b1;
                    ready_half_q <= ptr_q[ADDRESS_WIDTH-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reader handshake and sticky status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // A new half always becomes pending, even if it overran the last.
            pending_q <= half_ready_q | (pending_q & ~half_ack);
            // An ack arriving with the new half retires the old one in time.
            if (half_ready_q && pending_q && !half_ack) begin
                overrun_q <= 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign conv_start = (state_q == StStart);
    assign write      = writing;
    assign address    = ptr_q;
    assign data_in    = data_q;
    assign half_ready = half_ready_q;
    assign ready_half = ready_half_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_adc_capture_writer.sv
// Testbench for adc_capture_writer: directed vectors with hand-computed
// expectations, driven against a small behavioural ADC that raises eoc a
// fixed delay after the conversion-start pulse ends.

module tb_adc_capture_writer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CPS   = 20;
    localparam int unsigned CPC   = 2;
    localparam int unsigned TO    = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] din = '0;
    logic          eoc = 1'b0;
    logic          half_ack = 1'b0;
    logic          conv_start;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          write;
    logic          half_ready;
    logic          ready_half;
    logic          overrun;
    logic          timeout;

    always #5 clk = ~clk;

    adc_capture_writer #(
        .DATA_WIDTH       (DW),
        .DEPTH            (DEPTH),
        .ADDRESS_WIDTH    (AW),
        .CLKS_PER_SAMPLE  (CPS),
        .CONV_PULSE_CLKS  (CPC),
        .EOC_TIMEOUT_CLKS (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .din        (din),
        .eoc        (eoc),
        .conv_start (conv_start),
        .address    (address),
        .data_in    (data_in),
        .write      (write),
        .half_ready (half_ready),
        .ready_half (ready_half),
        .half_ack   (half_ack),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: eoc rises 3 cycles after conv_start falls, held 8 cycles.
    logic [DW-1:0] adc_din = '0;
    bit            adc_respond = 1'b0;
    int            eoc_cyc = 0;

    initial begin
        forever begin
            @(negedge conv_start);
            repeat (3) @(posedge clk);
            #1;
            if (adc_respond) begin
                din = adc_din;
                eoc = 1'b1;
                eoc_cyc = cyc;
                repeat (8) @(posedge clk);
                #1;
                eoc = 1'b0;
            end
        end
    end

    // Monitor of output events, sampled on the falling edge.
    int            wr_count = 0;
    int            hr_count = 0;
    int            cs_rises = 0;
    int            cs_len = 0;
    int            cs_last_len = 0;
    int            wr_cyc = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic          cs_prev = 1'b0;

    always @(negedge clk) begin
        if (write) begin
            wr_count++;
            last_addr = address;
            last_data = data_in;
            wr_cyc = cyc;
        end
        if (half_ready) hr_count++;
        if (conv_start) begin
            if (!cs_prev) begin
                cs_rises++;
                cs_len = 1;
            end else begin
                cs_len++;
            end
        end else if (cs_prev) begin
            cs_last_len = cs_len;
        end
        cs_prev = conv_start;
    end

    // Reader model: one-cycle ack per request, or an ack coincident with half_ready.
    int ack_reqs = 0;
    int ack_done = 0;
    bit coinc_mode = 1'b0;

    always @(negedge clk) begin
        if (ack_done != ack_reqs) begin
            half_ack = 1'b1;
            ack_done++;
        end else begin
            half_ack = coinc_mode && half_ready;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cs_rise(input string name);
        int target;
        int n;
        target = cs_rises + 1;
        n = 0;
        while (cs_rises < target && n < 100) begin
            step();
            n++;
        end
        if (cs_rises < target) begin
            checks++;
            failures++;
            $display("FAIL %s: conv_start did not rise within 100 cycles", name);
        end
    endtask

    task automatic wait_writes(input string name, input int count);
        int target;
        int n;
        target = wr_count + count;
        n = 0;
        while (wr_count < target && n < 40 * count + 60) begin
            step();
            n++;
        end
        if (wr_count < target) begin
            checks++;
            failures++;
            $display("FAIL %s: saw %0d of %0d writes", name, count - (target - wr_count), count);
        end
    endtask

    typedef struct {
        logic [DW-1:0] din;
        bit            respond;
        bit            ack;
        int            wrote;
        logic [AW-1:0] addr;
        int            hr;
        bit            rh;
        bit            ovr;
        bit            to;
    } vec_t;

    function automatic vec_t mk(input logic [DW-1:0] d, input bit resp, input bit ack,
                                input int wrote, input logic [AW-1:0] addr, input int hr,
                                input bit rh, input bit ovr, input bit to);
        vec_t v;
        v.din = d;
        v.respond = resp;
        v.ack = ack;
        v.wrote = wrote;
        v.addr = addr;
        v.hr = hr;
        v.rh = rh;
        v.ovr = ovr;
        v.to = to;
        return v;
    endfunction

    vec_t vecs[22];

    initial begin
        int w0;
        int hr0;
        int cs0;
        int n;
        string tag;

        //            din    rsp ack wr addr hr rh ov to
        vecs[0]  = mk(8'h01, 1, 0, 1, 3'd0, 0, 0, 0, 0);
        vecs[1]  = mk(8'h02, 1, 0, 1, 3'd1, 0, 0, 0, 0);
        vecs[2]  = mk(8'h03, 1, 0, 1, 3'd2, 0, 0, 0, 0);
        vecs[3]  = mk(8'h04, 1, 0, 1, 3'd3, 1, 0, 0, 0);
        vecs[4]  = mk(8'h05, 1, 1, 1, 3'd4, 1, 0, 0, 0);
        vecs[5]  = mk(8'h06, 1, 0, 1, 3'd5, 1, 0, 0, 0);
        vecs[6]  = mk(8'h07, 1, 0, 1, 3'd6, 1, 0, 0, 0);
        vecs[7]  = mk(8'h08, 1, 0, 1, 3'd7, 2, 1, 0, 0);
        vecs[8]  = mk(8'h09, 1, 1, 1, 3'd0, 2, 1, 0, 0);
        vecs[9]  = mk(8'h0A, 1, 0, 1, 3'd1, 2, 1, 0, 0);
        vecs[10] = mk(8'h0B, 1, 0, 1, 3'd2, 2, 1, 0, 0);
        vecs[11] = mk(8'h0C, 1, 0, 1, 3'd3, 3, 0, 0, 0);
        vecs[12] = mk(8'h0D, 1, 1, 1, 3'd4, 3, 0, 0, 0);
        vecs[13] = mk(8'h0E, 1, 0, 1, 3'd5, 3, 0, 0, 0);
        vecs[14] = mk(8'h0F, 1, 0, 1, 3'd6, 3, 0, 0, 0);
        vecs[15] = mk(8'h10, 1, 0, 1, 3'd7, 4, 1, 0, 0);
        vecs[16] = mk(8'h11, 1, 0, 1, 3'd0, 4, 1, 0, 0);
        vecs[17] = mk(8'h12, 1, 0, 1, 3'd1, 4, 1, 0, 0);
        vecs[18] = mk(8'h13, 1, 0, 1, 3'd2, 4, 1, 0, 0);
        vecs[19] = mk(8'h14, 1, 0, 1, 3'd3, 5, 0, 1, 0);
        vecs[20] = mk(8'hEE, 0, 0, 0, 3'd0, 5, 0, 1, 1);
        vecs[21] = mk(8'h55, 1, 0, 1, 3'd4, 5, 0, 1, 1);

        // Reset state
        #1 reset = 1'b1;
        repeat (3) step();
        check("rst_conv_start", conv_start, 0);
        check("rst_address", address, 0);
        check("rst_data_in", data_in, 0);
        check("rst_write", write, 0);
        check("rst_half_ready", half_ready, 0);
        check("rst_ready_half", ready_half, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        repeat (3) step();
        check("idle_conv_start", conv_start, 0);
        check("idle_write", write, 0);

        // Single sample: latency from eoc edge and pulse width
        enable = 1'b1;
        adc_din = 8'hA5;
        adc_respond = 1'b1;
        wait_cs_rise("single_cs");
        wait_writes("single_wr", 1);
        check("single_latency", wr_cyc - eoc_cyc, 4);
        check("single_addr", last_addr, 0);
        check("single_data", last_data, 8'hA5);
        check("conv_pulse_len", cs_last_len, CPC);

        reset = 1'b1;
        step();
        reset = 1'b0;

        // Table: half fills, handshake, overrun, timeout
        hr0 = hr_count;
        for (int i = 0; i < 22; i++) begin
            tag = $sformatf("vec%0d", i);
            adc_din = vecs[i].din;
            adc_respond = vecs[i].respond;
            wait_cs_rise({tag, "_cs"});
            if (vecs[i].ack) ack_reqs++;
            w0 = wr_count;
            repeat (16) step();
            check({tag, "_nwrites"}, wr_count - w0, vecs[i].wrote);
            if (vecs[i].wrote == 1) begin
                check({tag, "_addr"}, last_addr, vecs[i].addr);
                check({tag, "_data"}, last_data, vecs[i].din);
            end
            check({tag, "_half_ready_cnt"}, hr_count - hr0, vecs[i].hr);
            check({tag, "_ready_half"}, ready_half, vecs[i].rh);
            check({tag, "_overrun"}, overrun, vecs[i].ovr);
            check({tag, "_timeout"}, timeout, vecs[i].to);
        end

        // Enable dropped during WAIT_EOC: sample still written, ptr retained
        adc_din = 8'h66;
        adc_respond = 1'b1;
        wait_cs_rise("endrop_cs");
        repeat (2) step();
        enable = 1'b0;
        wait_writes("endrop_wr", 1);
        check("endrop_addr", last_addr, 5);
        check("endrop_data", last_data, 8'h66);
        cs0 = cs_rises;
        repeat (60) step();
        check("endrop_no_conv", cs_rises - cs0, 0);
        enable = 1'b1;
        adc_din = 8'h77;
        wait_cs_rise("resume_cs");
        wait_writes("resume_wr", 1);
        check("resume_addr", last_addr, 6);
        check("resume_data", last_data, 8'h77);

        // Reset asserted during the write strobe
        adc_din = 8'h88;
        wait_cs_rise("rstwr_cs");
        n = 0;
        while (!write && n < 40) begin
            step();
            n++;
        end
        check("rstwr_write_seen", write, 1);
        reset = 1'b1;
        #1;
        check("rstwr_write", write, 0);
        check("rstwr_address", address, 0);
        check("rstwr_data_in", data_in, 0);
        check("rstwr_overrun", overrun, 0);
        check("rstwr_timeout", timeout, 0);
        step();
        reset = 1'b0;

        // Ack coincident with half_ready: no overrun, half stays pending
        hr0 = hr_count;
        wait_writes("coinc_fill0", 4);
        repeat (3) step();
        coinc_mode = 1'b1;
        wait_writes("coinc_fill1", 4);
        repeat (3) step();
        coinc_mode = 1'b0;
        check("coinc_hr_cnt", hr_count - hr0, 2);
        check("coinc_ready_half", ready_half, 1);
        check("coinc_overrun", overrun, 0);
        wait_writes("coinc_fill2", 4);
        repeat (3) step();
        check("after_coinc_ready_half", ready_half, 0);
        check("after_coinc_overrun", overrun, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
